mem_arbiter: RTL and testbench

- Shares the single main-memory port between the I-cache line-fill path and the D-cache fill/writeback path.
- Sequences each granted request as a LINE_WORDS-word burst of single-word memory handshakes.
- Produces the i_rdy/d_rdy levels that the hazard unit combines into cache_stall.
- Sits between both cache controllers and the memory model.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-cache fills and D-cache fill/writeback bursts
// Optional MEM_ARB_FAIR_EN: grant I instead of D once STARVE_LIM back-to-back D grants have starved it.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int STARVE_LIM = 2,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic              d_done,
  output logic              d_grant,
  output logic [IDX_W-1:0]  word_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LINE_WORDS - 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, DONE} state_t;

  state_t            state_q, state_d;
  logic              gap_q, gap_d;
  logic              owner_d_q, owner_d_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              ifv_q, ifv_d;
  logic              dfv_q, dfv_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              fair_grant;
  logic              in_burst;

`ifdef MEM_ARB_FAIR_EN
  assign fair_grant = i_req && d_req && (starve_q == STARVE_MAX);
`else
  assign fair_grant = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    owner_d_d   = owner_d_q;
    we_d        = we_q;
    base_d      = base_q;
    idx_d       = idx_q;
    fill_data_d = fill_data_q;
    ifv_d       = 1'b0;
    dfv_d       = 1'b0;
    starve_d    = starve_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        gap_d = 1'b0;
        if (d_req && !fair_grant) begin
          state_d   = D_BURST;
          base_d    = d_addr & ~LINE_MASK;
          we_d      = d_we;
          owner_d_d = 1'b1;
          if (!i_req) starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
        end else if (i_req) begin
          state_d   = I_BURST;
          base_d    = i_addr & ~LINE_MASK;
          we_d      = 1'b0;
          owner_d_d = 1'b0;
          starve_d  = '0;
        end else begin
          starve_d = '0;
        end
      end
      I_BURST, D_BURST: begin
        // word_idx advances only after the gap so fill_valid reports the acked index
        if (gap_q) begin
          gap_d = 1'b0;
          idx_d = idx_q + 1'b1;
        end else if (mem_ack) begin
          fill_data_d = mem_rdata;
          ifv_d       = !owner_d_q && !we_q;
          dfv_d       = owner_d_q && !we_q;
          if (idx_q == LAST_IDX) state_d = DONE;
          else gap_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_q       <= 1'b0;
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      fill_data_q <= '0;
      ifv_q       <= 1'b0;
      dfv_q       <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      owner_d_q   <= owner_d_d;
      we_q        <= we_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      fill_data_q <= fill_data_d;
      ifv_q       <= ifv_d;
      dfv_q       <= dfv_d;
      starve_q    <= starve_d;
    end
  end

  assign in_burst     = (state_q == I_BURST) || (state_q == D_BURST);
  assign mem_req      = in_burst && !gap_q;
  assign mem_we       = mem_req && we_q;
  assign mem_addr     = mem_req ? (base_q + ADDR_W'(idx_q)) : '0;
  assign mem_wdata    = (mem_req && we_q) ? d_wdata : '0;
  assign d_grant      = (state_q == D_BURST);
  assign i_done       = (state_q == DONE) && !owner_d_q;
  assign d_done       = (state_q == DONE) && owner_d_q;
  assign i_rdy        = !i_req || i_done;
  assign d_rdy        = !d_req || d_done;
  assign word_idx     = idx_q;
  assign fill_data    = fill_data_q;
  assign i_fill_valid = ifv_q;
  assign d_fill_valid = dfv_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a burst-level reference model
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int SL = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req, d_req, d_we, i_rdy, i_done, d_rdy, d_done, d_grant;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, fill_data, mem_wdata, mem_rdata;
  logic [IW-1:0] word_idx;
  logic          i_fill_valid, d_fill_valid, mem_req, mem_we, mem_ack;
  logic [DW-1:0] wpat;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .STARVE_LIM(SL)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_done(d_done), .d_grant(d_grant),
    .word_idx(word_idx), .fill_data(fill_data),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign d_wdata = wpat + DW'(word_idx);

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return DW'(16'hA000) + DW'(a);
  endfunction

  // memory responder: acks after a per-word latency, may emit stray acks while idle
  int lat_min = 2, lat_max = 2, r_cnt = 0, r_lat = 0;
  bit spur_en = 0;
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (r_cnt == 0) r_lat = $urandom_range(lat_max, lat_min);
        if (r_cnt >= r_lat) begin
          mem_ack = 1'b1;
          mem_rdata = rd(mem_addr);
          r_cnt = 0;
        end else r_cnt++;
      end else begin
        r_cnt = 0;
        if (spur_en && $urandom_range(7, 0) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = DW'($urandom);
        end
      end
    end
  end

  // reference model: which burst owns the port and where it stands in its word sequence
  localparam int P_IDLE = 0, P_WORD = 1, P_GAP = 2, P_FIN = 3;
  int            m_ph = P_IDLE;
  bit            m_dside = 0, m_we = 0, m_fv = 0;
  logic [AW-1:0] m_base = '0;
  int            m_k = 0, m_fk = 0, m_starve = 0;
  logic [DW-1:0] m_fdata = '0;

  logic [AW-1:0] lg_addr[$];
  logic [DW-1:0] lg_wdata[$];
  bit            lg_we[$];
  logic [DW-1:0] lg_fdata[$];
  int            lg_fidx[$];
  bit            lg_fside[$];
  int            lg_start_cyc[$];
  bit            lg_start_d[$];
  int            lg_done_cyc[$];
  bit            lg_done_d[$];
  int            lg_idone = 0, lg_ddone = 0;
  bit            prev_req = 0;

  task automatic clear_logs();
    lg_addr.delete(); lg_wdata.delete(); lg_we.delete();
    lg_fdata.delete(); lg_fidx.delete(); lg_fside.delete();
    lg_start_cyc.delete(); lg_start_d.delete();
    lg_done_cyc.delete(); lg_done_d.delete();
    lg_idone = 0; lg_ddone = 0;
  endtask

  initial begin
    bit e_idone, e_ddone, e_req, fair;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        e_req   = (m_ph == P_WORD);
        e_idone = (m_ph == P_FIN) && !m_dside;
        e_ddone = (m_ph == P_FIN) && m_dside;
        chk("i_rdy", i_rdy, !i_req || e_idone);
        chk("d_rdy", d_rdy, !d_req || e_ddone);
        chk("i_done", i_done, e_idone);
        chk("d_done", d_done, e_ddone);
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, e_req && m_we);
        chk("mem_addr", mem_addr, e_req ? m_base + AW'(m_k) : '0);
        chk("mem_wdata", mem_wdata, (e_req && m_we) ? wpat + DW'(m_k) : '0);
        chk("d_grant", d_grant, m_dside && (m_ph == P_WORD || m_ph == P_GAP));
        chk("i_fill_valid", i_fill_valid, m_fv && !m_dside);
        chk("d_fill_valid", d_fill_valid, m_fv && m_dside);
        if (m_ph == P_WORD) chk("word_idx", word_idx, m_k);
        if (m_ph == P_IDLE) chk("word_idx_idle", word_idx, 0);
        if (m_fv) begin
          chk("fill_idx", word_idx, m_fk);
          chk("fill_data", fill_data, m_fdata);
        end

        if (mem_req && mem_ack && !rst) begin
          lg_addr.push_back(mem_addr); lg_wdata.push_back(mem_wdata); lg_we.push_back(mem_we);
        end
        if (i_fill_valid || d_fill_valid) begin
          lg_fdata.push_back(fill_data); lg_fidx.push_back(int'(word_idx)); lg_fside.push_back(d_fill_valid);
        end
        if (i_done) lg_idone++;
        if (d_done) lg_ddone++;
        if (i_done || d_done) begin
          lg_done_cyc.push_back(cyc); lg_done_d.push_back(d_done);
        end
        if (mem_req && !prev_req && word_idx == 0) begin
          lg_start_cyc.push_back(cyc); lg_start_d.push_back(d_grant);
        end
        prev_req = mem_req;

        if (rst) begin
          m_ph = P_IDLE; m_fv = 0; m_starve = 0;
        end else begin
          m_fv = 0;
          case (m_ph)
            P_IDLE: begin
`ifdef MEM_ARB_FAIR_EN
              fair = i_req && d_req && (m_starve == SL);
`else
              fair = 0;
`endif
              if (d_req && !fair) begin
                m_ph = P_WORD; m_dside = 1; m_we = d_we; m_k = 0;
                m_base = AW'((int'(d_addr) / LW) * LW);
                m_starve = i_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
              end else if (i_req) begin
                m_ph = P_WORD; m_dside = 0; m_we = 0; m_k = 0;
                m_base = AW'((int'(i_addr) / LW) * LW);
                m_starve = 0;
              end else m_starve = 0;
            end
            P_WORD: if (mem_ack) begin
              if (!m_we) begin
                m_fv = 1; m_fk = m_k; m_fdata = rd(m_base + AW'(m_k));
              end
              m_ph = (m_k == LW - 1) ? P_FIN : P_GAP;
            end
            P_GAP: begin m_k++; m_ph = P_WORD; end
            default: m_ph = P_IDLE;
          endcase
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit dside, input bit scramble);
    bit ok = 0;
    bit scr = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (dside ? d_done : i_done) ok = 1;
      else if (scramble && !scr && mem_req && (d_grant == dside)) begin
        scr = 1;
        @(posedge clk); #1;
        if (dside) begin d_addr = AW'($urandom); d_we = ~d_we; end
        else i_addr = AW'($urandom);
      end
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL wait_done side=%0d: got no done pulse, expected one within 600 cycles", dside);
    end
    @(posedge clk); #1;
    if (dside) d_req = 0; else i_req = 0;
  endtask

  task automatic agent(input bit dside, input int n);
    for (int t = 0; t < n; t++) begin
      tick($urandom_range(6, 1));
      if (dside) begin
        d_addr = AW'($urandom); d_we = $urandom_range(1, 0); wpat = DW'($urandom); d_req = 1;
      end else begin
        i_addr = AW'($urandom); i_req = 1;
      end
      wait_done(dside, $urandom_range(1, 0));
    end
  endtask

  initial begin
    int cnt;
    int owners[$];
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; wpat = '0;
    tick(3);
    @(negedge clk);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_word_idx", word_idx, 0);
    chk("reset_fill_data", fill_data, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_i_rdy", i_rdy, 1);
    @(posedge clk); #1;
    i_req = 1;
    @(negedge clk);
    chk("reset_i_rdy_req", i_rdy, 0);
    @(posedge clk); #1;
    i_req = 0; rst = 0;
    tick(2);

    clear_logs();
    i_addr = 16'h0123; i_req = 1;
    wait_done(0, 0);
    tick(3);
    chk("ifill_words", lg_addr.size(), 4);
    chk("ifill_fills", lg_fdata.size(), 4);
    for (int k = 0; k < 4 && k < lg_addr.size(); k++) chk("ifill_addr", lg_addr[k], 16'h0120 + k);
    for (int k = 0; k < 4 && k < lg_fdata.size(); k++) begin
      chk("ifill_data", lg_fdata[k], 16'hA120 + k);
      chk("ifill_idx", lg_fidx[k], k);
      chk("ifill_side", lg_fside[k], 0);
    end
    chk("ifill_done_cnt", lg_idone, 1);

    clear_logs();
    d_addr = 16'h0040; d_we = 1; wpat = 16'h5500; d_req = 1;
    wait_done(1, 0);
    tick(3);
    chk("dwb_words", lg_addr.size(), 4);
    for (int k = 0; k < 4 && k < lg_addr.size(); k++) begin
      chk("dwb_addr", lg_addr[k], 16'h0040 + k);
      chk("dwb_data", lg_wdata[k], 16'h5500 + k);
      chk("dwb_we", lg_we[k], 1);
    end
    chk("dwb_no_fill", lg_fdata.size(), 0);
    chk("dwb_done_cnt", lg_ddone, 1);

    clear_logs();
    lat_min = 0; lat_max = 3;
    d_addr = 16'h0081; d_we = 0; i_addr = 16'h0305; d_req = 1; i_req = 1;
    wait_done(1, 0);
    wait_done(0, 0);
    tick(3);
    chk("simul_starts", lg_start_d.size(), 2);
    if (lg_start_d.size() >= 2 && lg_done_cyc.size() >= 1) begin
      chk("simul_first_d", lg_start_d[0], 1);
      chk("simul_second_i", lg_start_d[1], 0);
      chk("simul_i_start_gap", lg_start_cyc[1] - lg_done_cyc[0], 2);
    end

    clear_logs();
    lat_min = 0; lat_max = 1;
    i_addr = 16'h0400; d_addr = 16'h0500; d_we = 0; i_req = 1; d_req = 1;
    cnt = 0;
    for (int i = 0; i < 600 && owners.size() < 3; i++) begin
      @(negedge clk);
      if (i_done || d_done) owners.push_back(int'(d_done));
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    tick(3);
    chk("starve_grants", owners.size(), 3);
    if (owners.size() == 3) begin
      chk("starve_g1", owners[0], 1);
      chk("starve_g2", owners[1], 1);
`ifdef MEM_ARB_FAIR_EN
      chk("starve_g3", owners[2], 0);
`else
      chk("starve_g3", owners[2], 1);
`endif
    end

    clear_logs();
    lat_min = 1; lat_max = 1;
    i_addr = 16'h0207; i_req = 1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 2; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) cnt++;
    end
    chk("rstmid_acks", cnt, 2);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_req_low", mem_req, 0);
    @(negedge clk);
    chk("rstmid_restart_req", mem_req, 1);
    chk("rstmid_restart_addr", mem_addr, 16'h0204);
    chk("rstmid_restart_idx", word_idx, 0);
    chk("rstmid_no_done", lg_idone, 0);
    wait_done(0, 0);
    tick(2);
    chk("rstmid_one_done", lg_idone, 1);

    lat_min = 0; lat_max = 3; spur_en = 1;
    fork
      agent(0, 25);
      agent(1, 25);
    join
    spur_en = 0;
    tick(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 50000 cycles");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
